// File: rtl/mips_constantes.sv
// Shared MIPS constants: special instruction words, IF FSM encoding,
// PC step.
package mips_constantes;

  localparam logic [31:0] HALT_INSTRUCTION = 32'h0000_0000;
  localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0020;
  localparam int          PC_INCREMENTO    = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } estado_if_t;

endpackage

// File: rtl/etapa_fetch_memoria_instrucciones.sv
// Instruction RAM: debug write port, synchronous read port whose output
// register doubles as the IF/ID instruction register.
module memoria_instrucciones
  import mips_constantes::*;
#(
  parameter int ANCHO     = 32,
  parameter int BITS_ADDR = 10
) (
  input  logic                 i_clock,
  input  logic                 i_soft_reset,
  input  logic                 i_wr,
  input  logic [BITS_ADDR-1:0] i_addr_wr,
  input  logic [ANCHO-1:0]     i_data_wr,
  input  logic                 i_rd_en,
  input  logic                 i_burbuja,
  input  logic [BITS_ADDR-1:0] i_addr_rd,
  output logic [ANCHO-1:0]     o_data,
  output logic                 o_es_halt
);

  logic [ANCHO-1:0] mem [0:(1<<BITS_ADDR)-1];

  always_ff @(posedge i_clock) begin
    if (i_wr)
      mem[i_addr_wr] <= i_data_wr;
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset)
      o_data <= ANCHO'(NOP_BUBBLE);
    else if (i_burbuja)
      o_data <= ANCHO'(NOP_BUBBLE);
    else if (i_rd_en)
      o_data <= mem[i_addr_rd];
  end

  // HALT must be known on the same edge the word is captured
  assign o_es_halt = (mem[i_addr_rd] == ANCHO'(HALT_INSTRUCTION));

endmodule

// File: rtl/etapa_fetch.sv
// MIPS IF stage: PC, run/halt FSM, IF/ID register.
// Optional cycle counter when IF_CYCLE_COUNTER_EN is defined.
module etapa_fetch
  import mips_constantes::*;
#(
  parameter int CANT_BITS_INSTRUCTION = 32,
  parameter int CANT_BITS_PC          = 32,
  parameter int CANT_BITS_ADDR        = 10
) (
  input  logic                             i_clock,
  input  logic                             i_soft_reset,
  input  logic                             i_enable_etapa,
  input  logic                             i_stall,
  input  logic                             i_flush,
  input  logic [CANT_BITS_PC-1:0]          i_pc_target,
  input  logic                             i_wr_mem_load,
  input  logic [CANT_BITS_ADDR-1:0]        i_addr_mem_load,
  input  logic [CANT_BITS_INSTRUCTION-1:0] i_data_mem_load,
  output logic [CANT_BITS_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_PC-1:0]          o_pc,
  output logic [CANT_BITS_PC-1:0]          o_pc_plus_4,
  output logic                             o_valid,
  output logic                             o_halt
`ifdef IF_CYCLE_COUNTER_EN
  ,
  output logic [31:0]                      o_contador_ciclos
`endif
);

  estado_if_t estado, estado_sig;

  logic [CANT_BITS_PC-1:0] pc_reg;
  logic [CANT_BITS_PC-1:0] pc_mas_4;
  logic                    avanza;
  logic                    lee;
  logic                    es_halt;
  logic                    carga;

  assign avanza   = i_enable_etapa && (estado == ST_RUN);
  assign lee      = avanza && !i_flush && !i_stall;
  assign carga    = i_wr_mem_load && !i_enable_etapa;
  assign pc_mas_4 = pc_reg + CANT_BITS_PC'(PC_INCREMENTO);

  memoria_instrucciones #(
    .ANCHO     (CANT_BITS_INSTRUCTION),
    .BITS_ADDR (CANT_BITS_ADDR)
  ) u_mem (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .i_wr         (carga),
    .i_addr_wr    (i_addr_mem_load),
    .i_data_wr    (i_data_mem_load),
    .i_rd_en      (lee),
    .i_burbuja    (avanza && i_flush),
    .i_addr_rd    (pc_reg[CANT_BITS_ADDR+1:2]),
    .o_data       (o_instruction),
    .o_es_halt    (es_halt)
  );

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset)
      pc_reg <= '0;
    else if (avanza) begin
      if (i_flush)
        pc_reg <= {i_pc_target[CANT_BITS_PC-1:2], 2'b00};
      else if (!i_stall && !es_halt)
        pc_reg <= pc_mas_4;
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      o_pc        <= '0;
      o_pc_plus_4 <= '0;
      o_valid     <= 1'b0;
    end else if (avanza) begin
      if (i_flush)
        o_valid <= 1'b0;
      else if (!i_stall) begin
        o_pc        <= pc_reg;
        o_pc_plus_4 <= pc_mas_4;
        o_valid     <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset)
      estado <= ST_RUN;
    else
      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    if (lee && es_halt)
      estado_sig = ST_HALT;
  end

  always_comb begin
    o_halt = (estado == ST_HALT);
  end

`ifdef IF_CYCLE_COUNTER_EN
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset)
      o_contador_ciclos <= '0;
    else if (avanza)
      o_contador_ciclos <= o_contador_ciclos + 32'd1;
  end
`endif

endmodule
